// File: rtl/seq_addsub_pkg.sv
// Shared constants and state encoding for the sequential adder-subtractor.
package seq_addsub_pkg;

  // Width of the single carry-lookahead slice that is reused every cycle.
  localparam int CLA_SLICE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_addsub_cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] gen;
  logic [3:0] prop;
  logic [4:1] carry;

  // Generate/propagate terms and flattened lookahead carries.
  always_comb begin
    gen      = x & y;
    prop     = x ^ y;
    carry[1] = gen[0] | (prop[0] & ci);
    carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & ci);
    carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
             | (prop[2] & prop[1] & prop[0] & ci);
    carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0])
             | (prop[3] & prop[2] & prop[1] & prop[0] & ci);
    s        = prop ^ {carry[3:1], ci};
    co       = carry[4];
  end

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle adder-subtractor: one 4-bit CLA slice per cycle, LSB nibble first.
// Operands are shifted right each cycle so the active nibble always sits in
// the low bits; the partial result is shifted in from the top.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = CLA_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] sliceSum;
  logic             sliceCo;
  logic [WIDTH-1:0] partShift;
  logic             lastSlice;
  logic             acceptStart;

  cla4_slice u_slice (
    .x  (opA_q[SLICE-1:0]),
    .y  (opB_q[SLICE-1:0]),
    .ci (carry_q),
    .s  (sliceSum),
    .co (sliceCo)
  );

  assign partShift   = WIDTH'({sliceSum, part_q} >> SLICE);
  assign lastSlice   = (idx_q == IDXW'(NSLICE - 1));
  assign acceptStart = start && (state_q != RUN);

  // Next-state logic: capture on an accepted start, step one slice per RUN cycle.
  always_comb begin
    state_d = state_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: state_d = IDLE;
      RUN: begin
        opA_d   = opA_q >> SLICE;
        opB_d   = opB_q >> SLICE;
        carry_d = sliceCo;
        part_d  = partShift;
        idx_d   = IDXW'(idx_q + 1'b1);
        if (lastSlice) begin
          state_d = DONE;
          sum_d   = partShift;
          cout_d  = sliceCo;
          ovf_d   = (opA_q[SLICE-1] == opB_q[SLICE-1]) && (sliceSum[SLICE-1] != opA_q[SLICE-1]);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (acceptStart) begin
      state_d = RUN;
      opA_d   = a;
      opB_d   = b ^ {WIDTH{sub}};
      carry_d = sub ? 1'b1 : cin;
      idx_d   = '0;
      part_d  = '0;
    end
  end

  // State, operand and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub against a whole-word arithmetic model.
module tb_seq_addsub;

  localparam int WIDTH  = 16;
  localparam int NSLICE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  seq_addsub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the whole word.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mcin,
                       input logic msub, output logic [15:0] ms, output logic mc,
                       output logic mo);
    int sa;
    int sb;
    int sr;
    int ur;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (msub) begin
      sr = sa - sb;
      ur = int'(ma) - int'(mb);
      mc = (ma >= mb);
    end else begin
      sr = sa + sb + int'(mcin);
      ur = int'(ma) + int'(mb) + int'(mcin);
      mc = (ur > 65535);
    end
    ms = 16'(ur);
    mo = (sr > 32767) || (sr < -32768);
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb2, input logic tcin,
                        input logic tsub, input logic [15:0] es, input logic ec,
                        input logic eo, input string name);
    logic [15:0] held;
    int cyc;
    @(negedge clk);
    a = ta; b = tb2; cin = tcin; sub = tsub; start = 1'b1;
    held = sum;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      if (done === 1'b1) break;
      checks++;
      if (busy !== 1'b1 || sum !== held) begin
        errors++;
        $display("[TB] FAIL %s run-hold: busy=%b sum=%h required busy=1 sum=%h", name, busy, sum, held);
      end
      cyc++;
    end
    checks++;
    if (cyc != NSLICE) begin
      errors++;
      $display("[TB] FAIL %s latency: busy cycles=%0d required %0d", name, cyc, NSLICE);
    end
    checks++;
    if (sum !== es || cout !== ec || ovf !== eo) begin
      errors++;
      $display("[TB] FAIL %s result: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
               name, sum, cout, ovf, es, ec, eo);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s pulse: done=%b busy=%b required 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, sum, cout, ovf} !== 20'd0) begin
      errors++;
      $display("[TB] FAIL reset: busy=%b done=%b sum=%h cout=%b ovf=%b required all 0",
               busy, done, sum, cout, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "carry_b");
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "carry_cin");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_add");
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "ovf_sub");
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "borrow");
  endtask

  task automatic test_random();
    logic [15:0] ra, rb, es;
    logic rc, rs, ec, eo;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      model(ra, rb, rc, rs, es, ec, eo);
      run_op(ra, rb, rc, rs, es, ec, eo, "random");
    end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] held, es;
    logic ec, eo;
    int cyc;
    model(16'h1111, 16'h2222, 1'b0, 1'b0, es, ec, eo);
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
    held = sum;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < 20) begin
      if (done === 1'b1) break;
      checks++;
      if (sum !== held) begin
        errors++;
        $display("[TB] FAIL ignore hold: sum=%h required %h", sum, held);
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done !== 1'b1 || sum !== es || cout !== ec || ovf !== eo) begin
      errors++;
      $display("[TB] FAIL ignore result: done=%b sum=%h cout=%b ovf=%b required 1 %h %b %b",
               done, sum, cout, ovf, es, ec, eo);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ignore queued: busy=%b done=%b required 0 0", busy, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] qa[5];
    logic [15:0] qb[5];
    logic qc[5];
    logic qs[5];
    logic [15:0] es;
    logic ec, eo;
    int cyc;
    for (int i = 0; i < 5; i++) begin
      qa[i] = 16'($urandom); qb[i] = 16'($urandom); qc[i] = 1'($urandom); qs[i] = 1'($urandom);
    end
    @(negedge clk);
    a = qa[0]; b = qb[0]; cin = qc[0]; sub = qs[0]; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k < 4) begin
        a = qa[k+1]; b = qb[k+1]; cin = qc[k+1]; sub = qs[k+1];
      end else begin
        start = 1'b0;
      end
      cyc = 0;
      while (cyc < 20) begin
        @(negedge clk);
        if (done === 1'b1) break;
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL b2b busy op%0d: busy=%b required 1", k, busy);
        end
        cyc++;
      end
      checks++;
      if (cyc != NSLICE) begin
        errors++;
        $display("[TB] FAIL b2b period op%0d: busy cycles=%0d required %0d", k, cyc, NSLICE);
      end
      model(qa[k], qb[k], qc[k], qs[k], es, ec, eo);
      checks++;
      if (sum !== es || cout !== ec || ovf !== eo) begin
        errors++;
        $display("[TB] FAIL b2b result op%0d: sum=%h cout=%b ovf=%b required %h %b %b",
                 k, sum, cout, ovf, es, ec, eo);
      end
      if (k < 4) @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b idle: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_run();
    logic sawDone;
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "pre_reset");
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, sum, cout, ovf} !== 20'd0) begin
      errors++;
      $display("[TB] FAIL midrun reset: busy=%b done=%b sum=%h cout=%b ovf=%b required all 0",
               busy, done, sum, cout, ovf);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sawDone = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) sawDone = 1'b1;
    end
    checks++;
    if (sawDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrun abort: activity after reset=%b required 0", sawDone);
    end
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "post_reset");
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
